// File: rtl/thread_dispatcher.sv
// Buffers scheduled threads in a small FIFO and offers each one to an idle core, round-robin.
// Optional offer timeout is enabled by defining THREAD_DISPATCH_TIMEOUT_EN.
module thread_dispatcher #(
  parameter int CPU_QUANTITY = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int TIMEOUT      = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tm_valid,
  input  logic [ADDR_W-1:0]             tm_addr,
  input  logic [DATA_W-1:0]             tm_data,
  output logic                          tm_ready,
  input  logic [CPU_QUANTITY-1:0]       cpu_idle,
  input  logic [CPU_QUANTITY-1:0]       cpu_ack,
  output logic [CPU_QUANTITY-1:0]       cpu_start,
  output logic [ADDR_W-1:0]             cpu_addr,
  output logic [DATA_W-1:0]             cpu_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic [7:0]                    timeout_cnt
);
  localparam int GW = (CPU_QUANTITY > 1) ? $clog2(CPU_QUANTITY) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  state_t                      r_state;
  logic [DATA_W+ADDR_W-1:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0]               r_wptr;
  logic [PW-1:0]               r_rptr;
  logic [CW-1:0]               r_cnt;
  logic [GW-1:0]               r_grant;
  logic [GW-1:0]               r_last_grant;
  logic [GW-1:0]               w_next_grant;
  logic [GW-1:0]               w_idx;
  logic                        w_found;
  logic                        w_push;
  logic                        w_pop;

  assign tm_ready = (r_cnt < CW'(FIFO_DEPTH));
  assign fifo_cnt = r_cnt;
  assign w_push   = tm_valid && tm_ready;
  assign w_pop    = (r_state == S_OFFER) && cpu_ack[r_grant];

  // First idle core strictly after the last accepted grant, wrapping around.
  always_comb begin
    w_next_grant = r_last_grant;
    w_idx        = '0;
    w_found      = 1'b0;
    for (int i = 1; i <= CPU_QUANTITY; i++) begin
      w_idx = GW'((int'(r_last_grant) + i) % CPU_QUANTITY);
      if (!w_found && cpu_idle[w_idx]) begin
        w_next_grant = w_idx;
        w_found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {tm_data, tm_addr};
  end

`ifdef THREAD_DISPATCH_TIMEOUT_EN
  logic [15:0] r_timer;
  logic [7:0]  r_timeout_cnt;
  assign timeout_cnt = r_timeout_cnt;
`else
  assign timeout_cnt = 8'd0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_cnt         <= '0;
      r_grant       <= '0;
      r_last_grant  <= GW'(CPU_QUANTITY - 1);
      cpu_start     <= '0;
      cpu_addr      <= '0;
      cpu_data      <= '0;
`ifdef THREAD_DISPATCH_TIMEOUT_EN
      r_timer       <= '0;
      r_timeout_cnt <= '0;
`endif
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase

      case (r_state)
        S_IDLE: begin
          if ((r_cnt != '0) && (cpu_idle != '0)) begin
            r_state   <= S_OFFER;
            r_grant   <= w_next_grant;
            cpu_start <= CPU_QUANTITY'(1) << w_next_grant;
            {cpu_data, cpu_addr} <= r_mem[r_rptr];
`ifdef THREAD_DISPATCH_TIMEOUT_EN
            r_timer   <= '0;
`endif
          end
        end
        S_OFFER: begin
          // Ack takes priority over a simultaneous idle drop.
          if (cpu_ack[r_grant]) begin
            r_state      <= S_IDLE;
            cpu_start    <= '0;
            r_last_grant <= r_grant;
          end else if (!cpu_idle[r_grant]) begin
            r_state   <= S_IDLE;
            cpu_start <= '0;
          end
`ifdef THREAD_DISPATCH_TIMEOUT_EN
          else if (r_timer == 16'(TIMEOUT - 1)) begin
            r_state      <= S_IDLE;
            cpu_start    <= '0;
            r_last_grant <= r_grant;
            if (r_timeout_cnt != 8'hFF) r_timeout_cnt <= r_timeout_cnt + 8'd1;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/thread_dispatcher.md
# thread_dispatcher

Downstream stage of the threads manager: accepts each scheduled thread (entry address `next_proc` plus context word) and hands it to one idle CPU core. It buffers selected threads in a small FIFO, selects among idle cores round-robin, and holds a start offer until the chosen core acknowledges it. With this block the threads manager never stalls on a busy core.

## Interface
Parameters:
- `CPU_QUANTITY`, 4: number of CPU cores served (2..8).
- `FIFO_DEPTH`, 4: thread buffer entries (power of two, 2..16).
- `DATA_W`, 32: context word width.
- `ADDR_W`, 32: thread entry address width.
- `TIMEOUT`, 15: offer timeout in cycles (used only with the timeout feature).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tm_valid`  in  1  threads manager presents a thread this cycle.
- `tm_addr`  in  ADDR_W  thread entry address (`next_proc`).
- `tm_data`  in  DATA_W  thread context word.
- `tm_ready`  out  1  FIFO can accept; `count < FIFO_DEPTH`, combinational from the registered count.
- `cpu_idle`  in  CPU_QUANTITY  per-core idle flag.
- `cpu_ack`  in  CPU_QUANTITY  per-core acceptance of an offer.
- `cpu_start`  out  CPU_QUANTITY  one-hot offer; held until ack or withdraw.
- `cpu_addr`  out  ADDR_W  offered entry address; valid while `cpu_start != 0`.
- `cpu_data`  out  DATA_W  offered context word; valid while `cpu_start != 0`.
- `fifo_cnt`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `timeout_cnt`  out  8  saturating count of timed-out offers (0 when the timeout feature is off).

## Operation
- **Push:** `tm_valid && tm_ready` at a clock edge writes `{tm_data, tm_addr}` at the write pointer, and the write pointer advances. Pointers wrap modulo FIFO_DEPTH.
- **Full FIFO:** `tm_valid` is ignored when `tm_ready=0`, including a cycle where a pop also occurs. There is no bypass.
- **State machine:**
  - IDLE -> OFFER when FIFO is non-empty and `cpu_idle != 0`. In that transition, `grant` is latched: the first idle core found by scanning from `last_grant+1` upward, wrapping around.
  - In OFFER:
    - `cpu_start[grant]=1`.
    - `cpu_addr` and `cpu_data` show the FIFO head.
  - OFFER -> IDLE on `cpu_ack[grant]`. The head is popped, and `last_grant` is set to `grant`.
  - OFFER -> IDLE on withdraw, i.e. `cpu_idle[grant]=0` with no ack that cycle. The head is retained, `last_grant` is unchanged, and the offer is retried.
- **Simultaneous ack and idle drop:** ack wins.
- **Acks from non-granted cores:** ignored.
- **Simultaneous push and pop:** `fifo_cnt` is unchanged and both pointers advance.
- **Widths:** `grant` is $clog2(CPU_QUANTITY) bits. Pointers are $clog2(FIFO_DEPTH) bits. The count is one bit wider, to represent a full FIFO.

## Timing
- **Reset values:**
  - `cpu_start=0`, `cpu_addr=0`, `cpu_data=0`, `fifo_cnt=0`, `tm_ready=1`, `timeout_cnt=0`.
  - State is IDLE.
  - `last_grant=CPU_QUANTITY-1`, so the first grant goes to core 0.
- **Reset mid-offer:** `cpu_start` drops asynchronously and buffered threads are discarded.
- **Latency:**
  - Push at edge N.
  - `fifo_cnt` becomes non-zero after edge N.
  - OFFER is entered at edge N+1 if a core is idle, so `cpu_start` is high in the cycle after N+1.
- **Ack:**
  - An ack sampled at edge M drops `cpu_start` after edge M.
  - The next offer (back-to-back) can start at edge M+1.
  - Minimum spacing between consecutive dispatches is 2 cycles.
- **Output stability:** `cpu_addr` and `cpu_data` are registered and stable for the whole OFFER period.

## Configuration
- **`THREAD_DISPATCH_TIMEOUT_EN` defined:**
  - An offer timer starts at 0 on entering OFFER.
  - If `TIMEOUT` cycles elapse with no ack and no withdraw, then:
    - the FSM returns to IDLE;
    - `last_grant=grant`, so the next offer goes to a different idle core if one exists;
    - the head is retained;
    - `timeout_cnt` increments, saturating at 255.
- **Macro undefined:** an offer waits indefinitely for ack or withdraw, and `timeout_cnt` is tied to 0.

## Test plan
- **Basic dispatch:**
  - After reset, with `cpu_idle=4'b1111`, push addr=0x100, data=0xA5.
  - Required: `cpu_start=4'b0001` with addr 0x100 and data 0xA5 one edge later.
  - Ack core 0, then `fifo_cnt=0`.
- **Round robin:**
  - With all cores idle, push 5 threads and ack each offer immediately.
  - Required: grants go to cores 0,1,2,3,0.
  - Required: payloads come out in push order.
- **Full FIFO:**
  - With `cpu_idle=0`, push 4 threads.
  - Required: `tm_ready=0` and `fifo_cnt=4`.
  - A fifth push while `tm_valid=1` is dropped.
  - Set `cpu_idle=1` and ack; required: FIFO drains to 3 and the fifth thread is never seen.
- **Withdraw:**
  - During an offer to core 2, drop `cpu_idle[2]` while core 3 is idle.
  - Required: the same head is re-offered to core 3.
  - Simultaneous ack plus idle drop on core 2 counts as accepted.
- **Timeout:**
  - With the macro defined, `TIMEOUT=15`, idle cores 0 and 1, and no acks.
  - Required: the offer to core 0 lasts 15 cycles, then the thread is re-offered to core 1, and `timeout_cnt=1`.
  - With the macro undefined, the core 0 offer persists for 100+ cycles.
- **Reset mid-offer:**
  - Assert `rst` asynchronously between edges during OFFER with 3 entries buffered.
  - Required: `cpu_start=0` immediately, and `fifo_cnt=0` with `tm_ready=1` on release.
